// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the in-flight write tag.
package cpu_pkg;
  localparam int REG_AW = 4;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
  } wtag_t;
endpackage

// File: rtl/inflight_tags.sv
// Shift pipe of pending register writes from decode issue to register-file writeback.
module inflight_tags
  import cpu_pkg::*;
#(
  parameter int INFLIGHT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  wtag_t             tag_in,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  output logic [NREGS-1:0]  busy_mask,
  output wtag_t             tag_last,
  output logic              match_ra,
  output logic              match_rb
);

  logic              vld_p [INFLIGHT];
  logic [REG_AW-1:0] rd_p  [INFLIGHT];

  // Stage 0 captures the issuing instruction; each later stage is one cycle older.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < INFLIGHT; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= tag_in.valid;
      for (int i = 1; i < INFLIGHT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_p[0] <= tag_in.rd;
    for (int i = 1; i < INFLIGHT; i++) rd_p[i] <= rd_p[i-1];
  end

  // The last stage is still busy: its register write lands at the end of this cycle.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < INFLIGHT; i++) begin
      if (vld_p[i]) busy_mask[rd_p[i]] = 1'b1;
    end
  end

  assign match_ra       = busy_mask[ra];
  assign match_rb       = busy_mask[rb];
  assign tag_last.valid = vld_p[INFLIGHT-1];
  assign tag_last.rd    = rd_p[INFLIGHT-1];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue controller: RAW stall, taken-branch squash and writeback-order check.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int INFLIGHT     = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_uses_ra,
  input  logic              id_uses_rb,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rwrite,
  input  logic              id_branch_taken,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              issue,
  output logic              flush,
  output logic [NREGS-1:0]  busy_mask,
  output logic              wb_error
);

  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES);

  wtag_t      tag_in;
  wtag_t      tag_last;
  logic       match_ra;
  logic       match_rb;
  logic       hz;
  logic       flushing;
  logic       armed;
  logic       wb_bad;
  logic [2:0] cnt;

  assign tag_in.valid = issue & id_rwrite;
  assign tag_in.rd    = id_rd;

  inflight_tags #(
    .INFLIGHT (INFLIGHT)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (tag_in),
    .ra        (id_ra),
    .rb        (id_rb),
    .busy_mask (busy_mask),
    .tag_last  (tag_last),
    .match_ra  (match_ra),
    .match_rb  (match_rb)
  );

  // armed drops asynchronously with reset so decode outputs are held low while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign hz       = id_valid & ((id_uses_ra & match_ra) | (id_uses_rb & match_rb));
  assign flushing = (cnt != 3'd0);
  assign stall    = armed & hz & ~flushing;
  assign issue    = armed & id_valid & ~hz & ~flushing;
  assign flush    = armed & flushing & id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= 3'd0;
    else if (issue & id_branch_taken) cnt <= FLUSH_LD;
    else if (flushing)                cnt <= cnt - 3'd1;
  end

  // Writeback stage boundary: the oldest tag must meet exactly one matching register write.
  assign wb_bad = (tag_last.valid & (~wb_valid | (wb_rd != tag_last.rd)))
                | (wb_valid & ~tag_last.valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_error <= 1'b0;
    else        wb_error <= wb_error | wb_bad;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with INFLIGHT=3, FLUSH_CYCLES=2.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_uses_ra, id_uses_rb, id_rwrite, id_branch_taken;
  logic [REG_AW-1:0] id_ra, id_rb, id_rd, wb_rd;
  logic              wb_valid;
  logic              stall, issue, flush, wb_error;
  logic [NREGS-1:0]  busy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.INFLIGHT(3), .FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_ra           (id_ra),
    .id_rb           (id_rb),
    .id_uses_ra      (id_uses_ra),
    .id_uses_rb      (id_uses_rb),
    .id_rd           (id_rd),
    .id_rwrite       (id_rwrite),
    .id_branch_taken (id_branch_taken),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .stall           (stall),
    .issue           (issue),
    .flush           (flush),
    .busy_mask       (busy_mask),
    .wb_error        (wb_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic i, input logic f);
    chk({tag, "_stall"}, 32'(stall), 32'(s));
    chk({tag, "_issue"}, 32'(issue), 32'(i));
    chk({tag, "_flush"}, 32'(flush), 32'(f));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                     input logic ura, input logic urb, input logic [3:0] rd,
                     input logic rw, input logic bt);
    id_valid = v; id_ra = ra; id_rb = rb; id_uses_ra = ura; id_uses_rb = urb;
    id_rd = rd; id_rwrite = rw; id_branch_taken = bt;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    wb_valid = v; wb_rd = r;
  endtask

  task automatic idle();
    dec(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    wb(1'b0, 4'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a valid taken branch presented: everything must stay low.
    rst_n = 1'b0;
    dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    wb(1'b0, 4'd0);
    #3;
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_wberr", 32'(wb_error), 32'h0);

    // Independent stream, writebacks on schedule.
    do_reset();
    cyc(); dec(1'b1, 4'd4, 4'd5, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0); #1;
    chk_out("ind0", 1'b0, 1'b1, 1'b0);
    chk("ind0_busy", 32'(busy_mask), 32'h0000);
    cyc(); dec(1'b1, 4'd6, 4'd7, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0); #1;
    chk_out("ind1", 1'b0, 1'b1, 1'b0);
    chk("ind1_busy", 32'(busy_mask), 32'h0002);
    cyc(); dec(1'b1, 4'd4, 4'd6, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0); #1;
    chk_out("ind2", 1'b0, 1'b1, 1'b0);
    chk("ind2_busy", 32'(busy_mask), 32'h0006);
    cyc(); idle(); wb(1'b1, 4'd1); #1;
    chk("ind3_busy", 32'(busy_mask), 32'h000E);
    cyc(); wb(1'b1, 4'd2); #1;
    chk("ind4_busy", 32'(busy_mask), 32'h000C);
    cyc(); wb(1'b1, 4'd3); #1;
    chk("ind5_busy", 32'(busy_mask), 32'h0008);
    cyc(); wb(1'b0, 4'd0); #1;
    chk("ind6_busy", 32'(busy_mask), 32'h0000);
    chk("ind6_wberr", 32'(wb_error), 32'h0);

    // RAW on ra: producer rd=5 at c0, consumer stalls c1..c3, issues c4.
    do_reset();
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0); #1;
    chk_out("raw0", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); dec(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
      wb(k == 3, 4'd5); #1;
      chk_out($sformatf("raw%0d", k), 1'b1, 1'b0, 1'b0);
      chk($sformatf("raw%0d_busy", k), 32'(busy_mask), 32'h0020);
    end
    cyc(); wb(1'b0, 4'd0); #1;
    chk_out("raw4", 1'b0, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk("raw5_busy", 32'(busy_mask), 32'h0100);
    cyc();
    cyc(); wb(1'b1, 4'd8);
    cyc(); wb(1'b0, 4'd0); #1;
    chk("raw8_wberr", 32'(wb_error), 32'h0);

    // Unused ra source does not stall; hazard on rb alone does.
    do_reset();
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0); #1;
    cyc(); dec(1'b1, 4'd5, 4'd2, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0); #1;
    chk_out("nouse1", 1'b0, 1'b1, 1'b0);
    cyc(); dec(1'b1, 4'd1, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0); #1;
    chk_out("rbhz2", 1'b1, 1'b0, 1'b0);
    cyc(); wb(1'b1, 4'd5); #1;
    chk_out("rbhz3", 1'b1, 1'b0, 1'b0);
    cyc(); wb(1'b0, 4'd0); #1;
    chk_out("rbhz4", 1'b0, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk("rbhz5_wberr", 32'(wb_error), 32'h0);

    // Taken branch at c0: squash c1..c2, resume c3; squashed rd=9 never busy.
    do_reset();
    cyc(); dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1); #1;
    chk_out("br0", 1'b0, 1'b1, 1'b0);
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0); #1;
    chk_out("br1", 1'b0, 1'b0, 1'b1);
    chk("br1_busy", 32'(busy_mask), 32'h0000);
    cyc(); #1;
    chk_out("br2", 1'b0, 1'b0, 1'b1);
    chk("br2_busy", 32'(busy_mask), 32'h0000);
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0); #1;
    chk_out("br3", 1'b0, 1'b1, 1'b0);
    chk("br3_busy", 32'(busy_mask), 32'h0000);

    // Writing taken branch rd=11: dependent is squashed (no stall), then stalls at c3.
    do_reset();
    cyc(); dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1); #1;
    chk_out("brw0", 1'b0, 1'b1, 1'b0);
    cyc(); dec(1'b1, 4'd11, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0); #1;
    chk_out("brw1", 1'b0, 1'b0, 1'b1);
    chk("brw1_busy", 32'(busy_mask), 32'h0800);
    cyc(); #1;
    chk_out("brw2", 1'b0, 1'b0, 1'b1);
    cyc(); wb(1'b1, 4'd11); #1;
    chk_out("brw3", 1'b1, 1'b0, 1'b0);
    cyc(); wb(1'b0, 4'd0); #1;
    chk_out("brw4", 1'b0, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk("brw5_wberr", 32'(wb_error), 32'h0);

    // Wrong writeback register: expected 5, got 6 at c3.
    do_reset();
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    cyc(); idle();
    cyc();
    cyc(); wb(1'b1, 4'd6); #1;
    chk("wbrd3_wberr", 32'(wb_error), 32'h0);
    cyc(); wb(1'b0, 4'd0); #1;
    chk("wbrd4_wberr", 32'(wb_error), 32'h1);
    cyc(); cyc(); #1;
    chk("wbrd6_sticky", 32'(wb_error), 32'h1);

    // Spurious writeback with an empty pipe.
    do_reset();
    chk("spur_rst_wberr", 32'(wb_error), 32'h0);
    cyc(); wb(1'b1, 4'd0); #1;
    chk("spur0_wberr", 32'(wb_error), 32'h0);
    cyc(); wb(1'b0, 4'd0); #1;
    chk("spur1_wberr", 32'(wb_error), 32'h1);

    // Missing writeback for rd=7.
    do_reset();
    cyc(); dec(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
    cyc(); idle();
    cyc();
    cyc(); #1;
    chk("miss3_wberr", 32'(wb_error), 32'h0);
    cyc(); #1;
    chk("miss4_wberr", 32'(wb_error), 32'h1);

    // Reset while a flush is counting and rd=3 is pending.
    do_reset();
    cyc(); dec(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1); #1;
    chk_out("mid0", 1'b0, 1'b1, 1'b0);
    cyc(); dec(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0); #1;
    chk_out("mid1", 1'b0, 1'b0, 1'b1);
    chk("mid1_busy", 32'(busy_mask), 32'h0008);
    #1 rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_busy", 32'(busy_mask), 32'h0000);
    cyc(); #1;
    chk_out("midrst2", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(); #1;
    chk_out("post", 1'b0, 1'b1, 1'b0);
    chk("post_wberr", 32'(wb_error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Issue controller for the decode stage. Tracks in-flight register writes between decode and register-file writeback, stalls decode on read-after-write hazards, squashes wrong-path instructions after a taken branch, and checks that writebacks arrive in the expected order. Sits beside the decode stage, taking its register fields and branch result, and drives fetch/decode hold and squash.

## Interface
- `INFLIGHT`, default 3: pipeline stages from decode issue to register-file write; legal range 1–8.
- `FLUSH_CYCLES`, default 2: wrong-path fetch slots squashed after a taken branch; legal range 1–7.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_ra`, `id_rb`  in  4 each  source register addresses.
- `id_uses_ra`, `id_uses_rb`  in  1 each  instruction actually reads that source.
- `id_rd`  in  4  destination register.
- `id_rwrite`  in  1  instruction writes `id_rd`.
- `id_branch_taken`  in  1  branch resolved taken in decode (branch AND compare result).
- `wb_valid`  in  1  register file is written this cycle.
- `wb_rd`  in  4  register being written.
- `stall`  out  1  hold PC and decode register.
- `issue`  out  1  decode instruction advances this cycle.
- `flush`  out  1  instruction in decode is squashed.
- `busy_mask`  out  16  bit n set while register n has a pending write.
- `wb_error`  out  1  sticky writeback-order violation.

## Operation
- Tag pipe: `INFLIGHT` entries of {valid, rd}. Every cycle the pipe shifts one stage. Entry 0 loads valid = `issue & id_rwrite` and rd = `id_rd`. The last entry drops out after one cycle.
- Hazard: `hz = id_valid & ((id_uses_ra & match(id_ra)) | (id_uses_rb & match(id_rb)))`. `match(r)` is true if any valid entry has rd == r.
  - The last stage counts as busy: its write lands at the end of the current cycle.
  - No forwarding. Register 0 gets no special treatment.
- Flush counter, 3 bits:
  - Loads `FLUSH_CYCLES` when `issue & id_branch_taken`.
  - Otherwise decrements while nonzero.
  - `flush = (cnt != 0) & id_valid`.
- Output equations:
  - `stall = hz & ~(cnt != 0)`.
  - `issue = id_valid & ~hz & (cnt == 0)`.
  - Squashed instructions never enter the tag pipe and never stall.
- Branch rules:
  - A hazarded branch stalls like any instruction.
  - `id_branch_taken` is ignored unless `issue` = 1.
  - A taken branch that also writes a register issues and enters the pipe normally.
- `busy_mask`: OR of onehot(rd) over all valid entries.
- Writeback check. Set `wb_error` (sticky until reset) when:
  - the last entry is valid and (`wb_valid` = 0 or `wb_rd` ≠ rd), or
  - `wb_valid` = 1 and the last entry is invalid.
- Reset (async, `rst_n` low):
  - Pipe all invalid, counter 0, `wb_error` 0.
  - `stall`, `issue`, `flush` forced 0 while `rst_n` is low.
  - `busy_mask` = 0.
  - Reset mid-branch or mid-hazard discards all pending state.

## Timing
- `stall`, `issue`, `flush` are combinational from current inputs and registered state, valid in the same cycle.
- Write-then-read spacing:
  - Producer issued in cycle t occupies stage k in cycle t+1+k.
  - Expected writeback in cycle t+`INFLIGHT`.
  - Earliest dependent issue is t+`INFLIGHT`+1. With `INFLIGHT`=3: issue at 0, dependent stalls cycles 1–3, issues at 4.
- Taken branch issued in cycle t: `flush` is asserted (when `id_valid`) in cycles t+1 … t+`FLUSH_CYCLES`. Normal issue resumes at t+`FLUSH_CYCLES`+1.
- A taken branch during an active flush cannot occur, because `issue` = 0 while cnt ≠ 0.
- `busy_mask` and `wb_error` are registered; `wb_error` rises the cycle after the violating cycle.

## Structure
- Shared package `cpu_pkg`:
  - `REG_AW` = 4 and `NREGS` = 16.
  - Packed typedef `wtag_t` {logic valid; logic [REG_AW-1:0] rd}.
- Sub-module `inflight_tags`: parameterised shift pipe of `wtag_t`.
  - Outputs `busy_mask` and the last entry.
  - Exposes a `match(ra, rb)` pair of outputs.
- `hazard_ctrl` holds the flush counter, the output equations and the writeback check.

## Test plan
- Independent stream (rd = 1,2,3; sources 4–7), `wb` driven on schedule → `issue` every cycle, `stall` never set, `wb_error` 0.
- RAW: issue rd=5 at cycle 0, next instruction reads ra=5 → `stall` = 1 in cycles 1–3, `issue` at 4, `busy_mask` = 0x0020 in cycles 1–3.
- Unused-source case: as above but `id_uses_ra` = 0 → no stall. Hazard on rb only → stall.
- Taken branch issued at cycle 10 with `id_valid` held high → `flush` in cycles 11–12, `issue` resumes at 13. Squashed rd=9 never appears in `busy_mask`.
- Writeback faults:
  - `wb_rd` = 6 when 5 is expected → `wb_error` = 1 next cycle and stays set.
  - Spurious `wb_valid` with an empty pipe → `wb_error` = 1.
- Assert `rst_n` low mid-stall with the flush counter loaded → all outputs 0 immediately. After release, decode issues on the first valid cycle.
